// File: rtl/resp_arbiter_pkg.sv
// Shared types and constants for the 2:1 TCDM response merge.
// Latency: n/a (package).
// Backpressure: n/a (package).
package resp_arbiter_pkg;

   localparam int RESP_NUM_IN = 2;

   typedef enum logic {
      SEL_IN0 = 1'b0,
      SEL_IN1 = 1'b1
   } rr_sel_e;

   // Round-robin advance for a two-input scheduler.
   function automatic rr_sel_e rr_other(input rr_sel_e sel);
      return (sel == SEL_IN0) ? SEL_IN1 : SEL_IN0;
   endfunction

endpackage

// File: rtl/resp_arbiter_fifo.sv
// Per-input response FIFO; registered storage, read data is the head entry.
// Latency: an entry written at edge N is visible on pop_data after edge N (no bypass).
// Backpressure: none on push; a push into a full FIFO is dropped and flagged by an assertion.
// Ports: clk, rst (async, active-high), push/push_data, pop/pop_data, occupancy, full, empty.
module resp_arbiter_fifo #(
   parameter int WIDTH = 39,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [OCC_W-1:0] occ;
   logic             do_push;
   logic             do_pop;

   assign full      = (occ == OCC_W'(DEPTH));
   assign empty     = (occ == '0);
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign pop_data  = mem[rptr];
   assign occupancy = occ;

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         occ  <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + PTR_W'(1);
         end
         if (do_pop) begin
            rptr <= rptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   overflow_chk : assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/resp_arbiter_bridge.sv
// Collision-safe 2:1 merge of TCDM responses: per-input FIFO, round-robin drain, registered output.
// Latency: 1 cycle for a lone response; +1 cycle per cycle lost to arbitration.
// Backpressure: no ready; stall0_o/stall1_o (registered) assert at next occupancy >= FIFO_DEPTH-1.
// Ports: clk, rst (async, active-high); data_r_{rdata,valid,opc,aux}{0,1}_i in;
//        stall{0,1}_o, data_r_{rdata,valid,opc,aux}_o out;
//        collision_cnt_o only when RESP_ARB_PERF_CNT_EN is defined.
module resp_arbiter_bridge
   import resp_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int AUX_WIDTH  = 6,
   parameter int FIFO_DEPTH = 4
`ifdef RESP_ARB_PERF_CNT_EN
   ,parameter int CNT_WIDTH = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_r_rdata0_i,
   input  logic                  data_r_valid0_i,
   input  logic                  data_r_opc0_i,
   input  logic [AUX_WIDTH-1:0]  data_r_aux0_i,
   input  logic [DATA_WIDTH-1:0] data_r_rdata1_i,
   input  logic                  data_r_valid1_i,
   input  logic                  data_r_opc1_i,
   input  logic [AUX_WIDTH-1:0]  data_r_aux1_i,
   output logic                  stall0_o,
   output logic                  stall1_o,
   output logic [DATA_WIDTH-1:0] data_r_rdata_o,
   output logic                  data_r_valid_o,
   output logic                  data_r_opc_o,
   output logic [AUX_WIDTH-1:0]  data_r_aux_o
`ifdef RESP_ARB_PERF_CNT_EN
   ,output logic [CNT_WIDTH-1:0] collision_cnt_o
`endif
);

   localparam int ENTRY_W = DATA_WIDTH + 1 + AUX_WIDTH;
   localparam int OCC_W   = $clog2(FIFO_DEPTH) + 1;

   logic [RESP_NUM_IN-1:0] push;
   logic [RESP_NUM_IN-1:0] pop;
   logic [RESP_NUM_IN-1:0] full;
   logic [RESP_NUM_IN-1:0] empty;
   logic [ENTRY_W-1:0]     wdata [RESP_NUM_IN];
   logic [ENTRY_W-1:0]     rdata [RESP_NUM_IN];
   logic [OCC_W-1:0]       occ   [RESP_NUM_IN];
   logic [OCC_W-1:0]       occ_nxt [RESP_NUM_IN];
   logic [RESP_NUM_IN-1:0] stall_q;
   rr_sel_e                rr_q;
   logic                   both_pending;

   assign push[0]  = data_r_valid0_i;
   assign push[1]  = data_r_valid1_i;
   assign wdata[0] = {data_r_rdata0_i, data_r_opc0_i, data_r_aux0_i};
   assign wdata[1] = {data_r_rdata1_i, data_r_opc1_i, data_r_aux1_i};

   for (genvar g = 0; g < RESP_NUM_IN; g++) begin : g_fifo
      resp_arbiter_fifo #(
         .WIDTH (ENTRY_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (push[g]),
         .push_data (wdata[g]),
         .pop       (pop[g]),
         .pop_data  (rdata[g]),
         .occupancy (occ[g]),
         .full      (full[g]),
         .empty     (empty[g])
      );
   end

   // Exactly one pop whenever anything is queued; RR only breaks ties.
   assign both_pending = ~empty[0] & ~empty[1];
   assign pop[0] = ~empty[0] & (empty[1] | (rr_q == SEL_IN0));
   assign pop[1] = ~empty[1] & (empty[0] | (rr_q == SEL_IN1));

   // Occupancy after this edge, mirroring the FIFO's drop-on-full rule.
   always_comb begin
      for (int i = 0; i < RESP_NUM_IN; i++) begin
         occ_nxt[i] = occ[i] + OCC_W'(push[i] & ~full[i]) - OCC_W'(pop[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q           <= SEL_IN0;
         stall_q        <= '0;
         data_r_valid_o <= 1'b0;
         data_r_rdata_o <= '0;
         data_r_opc_o   <= 1'b0;
         data_r_aux_o   <= '0;
      end else begin
         if (both_pending) begin
            rr_q <= rr_other(rr_q);
         end
         for (int i = 0; i < RESP_NUM_IN; i++) begin
            stall_q[i] <= (occ_nxt[i] >= OCC_W'(FIFO_DEPTH - 1));
         end
         data_r_valid_o <= |pop;
         // Payload holds its last value on idle cycles.
         if (|pop) begin
            {data_r_rdata_o, data_r_opc_o, data_r_aux_o} <= pop[1] ? rdata[1] : rdata[0];
         end
      end
   end

   assign stall0_o = stall_q[0];
   assign stall1_o = stall_q[1];

`ifdef RESP_ARB_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         collision_cnt_o <= '0;
      end else if (data_r_valid0_i && data_r_valid1_i && (collision_cnt_o != '1)) begin
         collision_cnt_o <= collision_cnt_o + CNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_resp_arbiter_bridge.sv
// Self-checking bench for resp_arbiter_bridge: directed scenarios plus a per-input scoreboard.
// Latency: n/a (testbench).
// Backpressure: request model honours stall with a one-cycle reaction lag.
module tb_resp_arbiter_bridge;

   typedef logic [38:0] ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] rdata0 = '0, rdata1 = '0;
   logic        valid0 = 1'b0, valid1 = 1'b0;
   logic        opc0 = 1'b0, opc1 = 1'b0;
   logic [5:0]  aux0 = '0, aux1 = '0;
   logic        stall0, stall1;
   logic [31:0] rdata_o;
   logic        valid_o;
   logic        opc_o;
   logic [5:0]  aux_o;
`ifdef RESP_ARB_PERF_CNT_EN
   logic [3:0]  coll_cnt;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   int   rx_cnt   = 0;
   ent_t q0[$];
   ent_t q1[$];
   int   src_log[$];

   always #5 clk = ~clk;

   resp_arbiter_bridge #(
      .DATA_WIDTH (32),
      .AUX_WIDTH  (6),
      .FIFO_DEPTH (4)
`ifdef RESP_ARB_PERF_CNT_EN
      ,.CNT_WIDTH (4)
`endif
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .data_r_rdata0_i (rdata0),
      .data_r_valid0_i (valid0),
      .data_r_opc0_i   (opc0),
      .data_r_aux0_i   (aux0),
      .data_r_rdata1_i (rdata1),
      .data_r_valid1_i (valid1),
      .data_r_opc1_i   (opc1),
      .data_r_aux1_i   (aux1),
      .stall0_o        (stall0),
      .stall1_o        (stall1),
      .data_r_rdata_o  (rdata_o),
      .data_r_valid_o  (valid_o),
      .data_r_opc_o    (opc_o),
      .data_r_aux_o    (aux_o)
`ifdef RESP_ARB_PERF_CNT_EN
      ,.collision_cnt_o (coll_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of stimulus; accepted responses go to the scoreboard.
   task automatic drive(input logic v0, input logic [31:0] d0, input logic o0, input logic [5:0] a0,
                        input logic v1, input logic [31:0] d1, input logic o1, input logic [5:0] a1);
      valid0 = v0; rdata0 = d0; opc0 = o0; aux0 = a0;
      valid1 = v1; rdata1 = d1; opc1 = o1; aux1 = a1;
      if (v0) q0.push_back({d0, o0, a0});
      if (v1) q1.push_back({d1, o1, a1});
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, '0, 0, '0, 0, '0, 0, '0);
   endtask

   task automatic do_reset();
      valid0 = 0; valid1 = 0;
      rst = 1'b1;
      q0.delete();
      q1.delete();
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   // Scoreboard: aux bit 5 identifies the source input in every stimulus used here.
   always @(negedge clk) begin
      if (!rst && valid_o) begin
         rx_cnt++;
         if (aux_o[5] == 1'b0) begin
            src_log.push_back(0);
            if (q0.size() == 0) check("sb_in0_unexpected", {rdata_o, opc_o, aux_o}, 0);
            else                check("sb_in0", {rdata_o, opc_o, aux_o}, q0.pop_front());
         end else begin
            src_log.push_back(1);
            if (q1.size() == 0) check("sb_in1_unexpected", {rdata_o, opc_o, aux_o}, 0);
            else                check("sb_in1", {rdata_o, opc_o, aux_o}, q1.pop_front());
         end
      end
   end

   initial begin
      int i0, i1, guard, rx_before;
      logic s0_cur, s1_cur, s0_prev, s1_prev, v0, v1;

      // Reset state
      #2 rst = 1'b1;
      #2;
      check("rst_valid", valid_o, 0);
      check("rst_rdata", rdata_o, 0);
      check("rst_opc",   opc_o,   0);
      check("rst_aux",   aux_o,   0);
      check("rst_stall0", stall0, 0);
      check("rst_stall1", stall1, 0);
      step();
      rst = 1'b0;
      step();

      // 1: single response, one-cycle latency, one-cycle pulse, payload held
      drive(1, 32'hA5A5_0001, 0, 6'h05, 0, '0, 0, '0);
      check("t1_valid_n", valid_o, 0);
      idle(1);
      check("t1_valid_n1", valid_o, 1);
      check("t1_rdata",    rdata_o, 32'hA5A5_0001);
      check("t1_aux",      aux_o,   6'h05);
      check("t1_opc",      opc_o,   0);
      idle(1);
      check("t1_valid_n2", valid_o, 0);
      check("t1_hold",     rdata_o, 32'hA5A5_0001);

      // 2: collision, input 0 preferred first
      drive(1, 32'h11, 1, 6'h01, 1, 32'h22, 0, 6'h21);
      idle(1);
      check("t2_valid_a", valid_o, 1);
      check("t2_rdata_a", rdata_o, 32'h11);
      check("t2_opc_a",   opc_o,   1);
      idle(1);
      check("t2_valid_b", valid_o, 1);
      check("t2_rdata_b", rdata_o, 32'h22);
      idle(1);
      check("t2_valid_c", valid_o, 0);

      // 3: sustained collisions up to (not past) full; alternation and stall rise
      do_reset();
      src_log.delete();
      for (int e = 1; e <= 6; e++) begin
         drive(1, 32'h3000_0000 + e, e[0], {1'b0, e[4:0]},
               1, 32'h3100_0000 + e, e[1], {1'b1, e[4:0]});
         if (e == 3) check("t3_stall1_e3", stall1, 0);
         if (e == 4) begin
            check("t3_stall1_e4", stall1, 1);
            check("t3_stall0_e4", stall0, 0);
         end
         if (e == 5) check("t3_stall0_e5", stall0, 1);
      end
      idle(8);
      check("t3_out_count", src_log.size(), 12);
      for (int i = 0; i < src_log.size(); i++) check("t3_alternate", src_log[i], i % 2);
      check("t3_stall0_end", stall0, 0);
      check("t3_stall1_end", stall1, 0);

      // 4: stall honoured with one cycle of reaction lag; 8 responses per input
      do_reset();
      rx_before = rx_cnt;
      i0 = 0; i1 = 0; guard = 0;
      s0_cur = 0; s1_cur = 0; s0_prev = 0; s1_prev = 0;
      while ((i0 < 8 || i1 < 8) && guard < 200) begin
         v0 = (i0 < 8) && !s0_prev;
         v1 = (i1 < 8) && !s1_prev;
         drive(v0, 32'h4000_0000 + i0, i0[0], {1'b0, i0[4:0]},
               v1, 32'h4100_0000 + i1, i1[1], {1'b1, i1[4:0]});
         if (v0) i0++;
         if (v1) i1++;
         s0_prev = s0_cur; s1_prev = s1_cur;
         s0_cur = stall0;  s1_cur = stall1;
         guard++;
      end
      if (guard >= 200) check("t4_timeout", 1, 0);
      idle(20);
      check("t4_rx_count", rx_cnt - rx_before, 16);
      check("t4_q0_drained", q0.size(), 0);
      check("t4_q1_drained", q1.size(), 0);

      // 5: mid-operation reset discards queued entries
      do_reset();
      for (int e = 0; e < 4; e++)
         drive(1, 32'h5000_0000 + e, 0, {1'b0, 5'(e)}, 1, 32'h5100_0000 + e, 0, {1'b1, 5'(e)});
      check("t5_stall1_pre", stall1, 1);
      valid0 = 0; valid1 = 0;
      rst = 1'b1;
      q0.delete();
      q1.delete();
      #1;
      check("t5_valid_rst",  valid_o, 0);
      check("t5_stall0_rst", stall0,  0);
      check("t5_stall1_rst", stall1,  0);
      step();
      rst = 1'b0;
      rx_before = rx_cnt;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         check("t5_valid_post", valid_o, 0);
         check("t5_stall_post", {stall0, stall1}, 0);
      end
      drive(0, '0, 0, '0, 1, 32'h5A5A_0000, 1, 6'h3F);
      idle(1);
      check("t5_new_valid", valid_o, 1);
      check("t5_new_rdata", rdata_o, 32'h5A5A_0000);
      idle(2);
      check("t5_rx_count", rx_cnt - rx_before, 1);

`ifdef RESP_ARB_PERF_CNT_EN
      // 6: collision counter saturates at all-ones and clears on reset
      do_reset();
      check("t6_cnt_rst", coll_cnt, 0);
      for (int c = 0; c < 20; c++) begin
         drive(1, 32'h6000_0000 + c, 0, {1'b0, 5'(c)}, 1, 32'h6100_0000 + c, 0, {1'b1, 5'(c)});
         idle(1);
         if (c == 4) check("t6_cnt_5", coll_cnt, 5);
      end
      check("t6_cnt_sat", coll_cnt, 15);
      idle(4);
      do_reset();
      check("t6_cnt_clr", coll_cnt, 0);
`endif

      check("end_q0_empty", q0.size(), 0);
      check("end_q1_empty", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
